// File: rtl/cross_bar_pkg.sv
// Shared types and helpers for the crossbar controller: sizing, connection
// number types, per-slave arbiter state and the address-to-slave decode.
package cross_bar_pkg;

  localparam int unsigned MASTER_N     = 4;
  localparam int unsigned SLAVE_N      = 4;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned SLAVE_W      = $clog2(SLAVE_N);
  localparam int unsigned MASTER_NUM_W = $clog2(MASTER_N + 1);
  localparam int unsigned SLAVE_NUM_W  = $clog2(SLAVE_N + 1);

  typedef logic [ADDR_W-1:0]       addr_t;
  typedef logic [MASTER_NUM_W-1:0] master_num_t;
  typedef logic [SLAVE_NUM_W-1:0]  slave_num_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_t;

  // Slave numbers are 1-based so that 0 can mean "no connection".
  function automatic slave_num_t slave_decode(input addr_t addr);
    logic [SLAVE_W-1:0] idx;
    idx = addr[ADDR_W-1 -: SLAVE_W];
    return slave_num_t'(idx) + slave_num_t'(1);
  endfunction

endpackage

// File: rtl/cross_bar_arb_rr.sv
// Per-slave round-robin arbiter: grants one requesting master and holds the
// connection through the whole req/ack handshake.
module cross_bar_arb_rr
  import cross_bar_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MASTER_N:1]   cand,
  input  logic [MASTER_N:1]   master_req,
  input  logic                ack,
  output master_num_t         owner,
  output logic [MASTER_N:1]   grant,
  output logic                busy
);

  arb_state_t  state_q, state_d;
  master_num_t owner_q, owner_d;
  master_num_t ptr_q, ptr_d;
  master_num_t pick;
  logic        pick_vld;
  int unsigned idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= master_num_t'(MASTER_N);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Scan ptr+1 .. MASTER_N, 1 .. ptr and take the first candidate.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= MASTER_N; i++) begin
      idx = ((32'(ptr_q) + i - 1) % MASTER_N) + 1;
      if (!pick_vld && cand[master_num_t'(idx)]) begin
        pick     = master_num_t'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_BUSY;
          owner_d = pick;
          ptr_d   = pick;
        end
      end
      ARB_BUSY: begin
        if (ack) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        if (!master_req[owner_q]) begin
          state_d = ARB_IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    owner = owner_q;
    busy  = (state_q != ARB_IDLE);
    grant = '0;
    for (int unsigned i = 1; i <= MASTER_N; i++) begin
      grant[i] = (owner_q == master_num_t'(i));
    end
  end

endmodule

// File: rtl/cross_bar_ctrl.sv
// Crossbar mux controller: decodes each master's target slave, arbitrates per
// slave and drives the slave-side and master-side mux selects.
module cross_bar_ctrl
  import cross_bar_pkg::*;
(
  input  logic                         clk,
  input  logic                         areset,
  input  logic        [MASTER_N:1]     master_req,
  input  addr_t       [MASTER_N:1]     master_addr,
  input  logic        [SLAVE_N:1]      slave_ack,
  output master_num_t [SLAVE_N:1]      slave_mux,
  output slave_num_t  [MASTER_N:1]     master_mux,
  output logic        [SLAVE_N:1]      slave_busy
);

  slave_num_t [MASTER_N:1]              target;
  logic       [SLAVE_N:1][MASTER_N:1]   cand;
  logic       [SLAVE_N:1][MASTER_N:1]   grant;
  logic                                 addr_unused;

  assign addr_unused = ^master_addr;

  always_comb begin
    target = '0;
    cand   = '0;
    for (int unsigned m = 1; m <= MASTER_N; m++) begin
      target[m] = slave_decode(master_addr[m]);
    end
    for (int unsigned s = 1; s <= SLAVE_N; s++) begin
      for (int unsigned m = 1; m <= MASTER_N; m++) begin
        cand[s][m] = master_req[m] && (target[m] == slave_num_t'(s));
      end
    end
  end

  for (genvar s = 1; s <= SLAVE_N; s++) begin : g_arb
    cross_bar_arb_rr u_arb (
      .clk        (clk),
      .rst        (areset),
      .cand       (cand[s]),
      .master_req (master_req),
      .ack        (slave_ack[s]),
      .owner      (slave_mux[s]),
      .grant      (grant[s]),
      .busy       (slave_busy[s])
    );
  end

  // A master holds at most one slave, so OR-ing the per-slave grants is exact.
  always_comb begin
    master_mux = '0;
    for (int unsigned s = 1; s <= SLAVE_N; s++) begin
      for (int unsigned m = 1; m <= MASTER_N; m++) begin
        if (grant[s][m]) master_mux[m] = master_mux[m] | slave_num_t'(s);
      end
    end
  end

  for (genvar m = 1; m <= MASTER_N; m++) begin : g_chk
    a_pair: assert property (@(posedge clk) disable iff (areset)
      (master_mux[m] != '0) |-> (slave_mux[master_mux[m]] == master_num_t'(m)));
  end

endmodule

// File: tb/tb_cross_bar_ctrl.sv
// Directed bench for cross_bar_ctrl: vector table plus hand-written reset and
// hold sequences.
module tb_cross_bar_ctrl;
  import cross_bar_pkg::*;

  localparam logic [31:0] AS1 = 32'h0000_0000;
  localparam logic [31:0] AS2 = 32'h4000_0000;
  localparam logic [31:0] AS3 = 32'hA000_0000;
  localparam logic [31:0] AS4 = 32'hD200_0004;

  logic                     clk = 1'b0;
  logic                     areset = 1'b0;
  logic        [4:1]        req = '0;
  logic        [4:1][31:0]  addr = '0;
  logic        [4:1]        ack = '0;
  master_num_t [4:1]        smux;
  slave_num_t  [4:1]        mmux;
  logic        [4:1]        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:1]       req;
    logic [4:1][31:0] addr;
    logic [4:1]       ack;
    logic [11:0]      smux;
    logic [11:0]      mmux;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  cross_bar_ctrl dut (
    .clk         (clk),
    .areset      (areset),
    .master_req  (req),
    .master_addr (addr),
    .slave_ack   (ack),
    .slave_mux   (smux),
    .master_mux  (mmux),
    .slave_busy  (busy)
  );

  function automatic logic [11:0] pk(input logic [2:0] x1, x2, x3, x4);
    return {x4, x3, x2, x1};
  endfunction

  function automatic logic [3:0] busy_of(input logic [11:0] s);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (s[3*i +: 3] != 3'd0);
    return b;
  endfunction

  function automatic void add(input logic [4:1] r, input logic [31:0] a1, a2, a3, a4,
                              input logic [4:1] k, input logic [2:0] s1, s2, s3, s4,
                              input logic [2:0] m1, m2, m3, m4);
    vec_t v;
    v.req  = r;
    v.addr = {a4, a3, a2, a1};
    v.ack  = k;
    v.smux = pk(s1, s2, s3, s4);
    v.mmux = pk(m1, m2, m3, m4);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] es, input logic [11:0] em);
    chk({name, " slave_mux"},  32'(smux), 32'(es));
    chk({name, " master_mux"}, 32'(mmux), 32'(em));
    chk({name, " slave_busy"}, 32'(busy), 32'(busy_of(es)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // parallel connections
    add(4'b0111, AS3, AS4, AS1, AS1, 4'b0000, 3, 0, 1, 2, 3, 4, 1, 0);
    add(4'b0111, AS3, AS4, AS1, AS1, 4'b1101, 3, 0, 1, 2, 3, 4, 1, 0);
    add(4'b0000, AS3, AS4, AS1, AS1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    // spurious ack on idle slave
    add(4'b0000, AS1, AS1, AS1, AS1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0000, AS1, AS1, AS1, AS1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    // contention on S2, then wrap back to M1
    add(4'b1111, AS2, AS2, AS2, AS2, 4'b0000, 0, 1, 0, 0, 2, 0, 0, 0);
    add(4'b1111, AS2, AS2, AS2, AS2, 4'b0010, 0, 1, 0, 0, 2, 0, 0, 0);
    add(4'b1110, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b1110, AS2, AS2, AS2, AS2, 4'b0000, 0, 2, 0, 0, 0, 2, 0, 0);
    add(4'b1110, AS2, AS2, AS2, AS2, 4'b0010, 0, 2, 0, 0, 0, 2, 0, 0);
    add(4'b1100, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b1100, AS2, AS2, AS2, AS2, 4'b0000, 0, 3, 0, 0, 0, 0, 2, 0);
    add(4'b1100, AS2, AS2, AS2, AS2, 4'b0010, 0, 3, 0, 0, 0, 0, 2, 0);
    add(4'b1000, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b1000, AS2, AS2, AS2, AS2, 4'b0000, 0, 4, 0, 0, 0, 0, 0, 2);
    add(4'b1000, AS2, AS2, AS2, AS2, 4'b0010, 0, 4, 0, 0, 0, 0, 0, 2);
    add(4'b0001, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0001, AS2, AS2, AS2, AS2, 4'b0000, 0, 1, 0, 0, 2, 0, 0, 0);
    add(4'b0001, AS2, AS2, AS2, AS2, 4'b0010, 0, 1, 0, 0, 2, 0, 0, 0);
    add(4'b0000, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    // release and new request on the same slave in one cycle
    add(4'b0010, AS2, AS2, AS2, AS2, 4'b0000, 0, 2, 0, 0, 0, 2, 0, 0);
    add(4'b0010, AS2, AS2, AS2, AS2, 4'b0010, 0, 2, 0, 0, 0, 2, 0, 0);
    add(4'b0100, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0100, AS2, AS2, AS2, AS2, 4'b0000, 0, 3, 0, 0, 0, 0, 2, 0);
    add(4'b0100, AS2, AS2, AS2, AS2, 4'b0010, 0, 3, 0, 0, 0, 0, 2, 0);
    add(4'b0000, AS2, AS2, AS2, AS2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    // ack and req drop together while BUSY
    add(4'b0001, AS1, AS1, AS1, AS1, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
    add(4'b0000, AS1, AS1, AS1, AS1, 4'b0001, 1, 0, 0, 0, 1, 0, 0, 0);
    add(4'b0000, AS1, AS1, AS1, AS1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);

    #1 areset = 1'b1;
    #1 chk_all("reset", '0, '0);
    @(negedge clk);
    areset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req  = vecs[i].req;
      addr = vecs[i].addr;
      ack  = vecs[i].ack;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].smux, vecs[i].mmux);
    end

    // async reset mid-BUSY: S2/S3 pointers are non-default beforehand
    @(negedge clk);
    req = 4'b0100; addr = {AS1, AS4, AS1, AS1}; ack = '0;
    step();
    chk_all("pre_reset", pk(0, 0, 0, 3), pk(0, 0, 4, 0));
    #2 areset = 1'b1;
    #1 chk_all("async_reset", '0, '0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    areset = 1'b0;

    // first contention after reset: M1 beats M4
    req = 4'b1001; addr = {AS2, AS1, AS1, AS2};
    step();
    chk_all("post_reset_win", pk(0, 1, 0, 0), pk(2, 0, 0, 0));
    @(negedge clk); ack = 4'b0010;
    step();
    @(negedge clk); ack = '0; req = 4'b1000;
    step();
    chk_all("post_reset_rel", '0, '0);
    step();
    chk_all("post_reset_m4", pk(0, 4, 0, 0), pk(0, 0, 0, 2));
    @(negedge clk); ack = 4'b0010;
    @(negedge clk); ack = '0; req = '0;
    step();
    chk_all("post_reset_idle", '0, '0);

    // hold: S3 ack delayed 10 clk with M2 pending
    @(negedge clk);
    req = 4'b0011; addr = {AS1, AS1, AS3, AS3};
    step();
    chk_all("hold_grant", pk(0, 0, 1, 0), pk(3, 0, 0, 0));
    for (int c = 0; c < 10; c++) begin
      step();
      chk_all($sformatf("hold_c%0d", c), pk(0, 0, 1, 0), pk(3, 0, 0, 0));
    end
    @(negedge clk); ack = 4'b0100;
    step();
    chk_all("hold_done", pk(0, 0, 1, 0), pk(3, 0, 0, 0));
    @(negedge clk); ack = '0; req = 4'b0010;
    step();
    chk_all("hold_release", '0, '0);
    step();
    chk_all("hold_m2", pk(0, 0, 2, 0), pk(0, 3, 0, 0));
    @(negedge clk); ack = 4'b0100;
    @(negedge clk); ack = '0; req = '0;
    step();
    chk_all("final_idle", '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
